// File: rtl/counter_pkg.sv
// Shared types and helpers for the divided 2-bit counter.
// Holds the count width/type and the divider width calculation.
package counter_pkg;

    localparam int CNT_W   = 2;
    localparam int DIV_MAX = 1 << 24;

    typedef logic [CNT_W-1:0] cnt_t;

    // Divider counter width: enough bits for 0 .. div-1, never narrower than one bit.
    function automatic int div_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

    // Modulo-4 increment; the natural wrap of the 2-bit type gives 3 -> 0.
    function automatic cnt_t cnt_inc(input cnt_t c);
        return c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Programmable divider producing a one-cycle enable tick every DIV clocks.
// No derived clock: tick is a plain enable in the clk domain.
module clk_div_tick
    import counter_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               DIV_W = div_width(DIV);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    // With DIV == 1 the counter is pinned at zero, so tick stays high.
    always_comb begin
        tick         = (div_cnt_reg == LAST);
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        if (tick) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

endmodule

// File: rtl/two_bit_counter_n_clock_divider.sv
// Free-running 2-bit up-counter advanced by a divided enable tick.
// Count bits drive outA (MSB) and outB (LSB) straight from the flops.
module two_bit_counter_n_clock_divider
    import counter_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic outA,
    output logic outB
);

    generate
        if (DIV < 1 || DIV > DIV_MAX) begin : g_bad_div
            $error("two_bit_counter_n_clock_divider: DIV=%0d outside 1..2^24", DIV);
        end
    endgenerate

    logic tick;
    cnt_t count_reg;
    cnt_t count_next;

    clk_div_tick #(
        .DIV (DIV)
    ) u_clk_div_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        count_next = count_reg;
        if (tick) begin
            count_next = cnt_inc(count_reg);
        end
    end

    // Reset wins over a coincident tick; both registers restart together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign outA = count_reg[1];
    assign outB = count_reg[0];

endmodule

// File: tb/tb_two_bit_counter_n_clock_divider.sv
// Bench for the divided 2-bit counter: four instances (DIV 2, 1, 5, 3) checked
// every edge against a scoreboard of expected counts derived from edges since release.
module tb_two_bit_counter_n_clock_divider;

    localparam int NU = 4;

    logic          clk = 1'b0;
    logic [NU-1:0] rst_v;
    logic [NU-1:0] oa;
    logic [NU-1:0] ob;

    always #40 clk = ~clk;

    two_bit_counter_n_clock_divider #(.DIV(2)) u_div2 (
        .clk (clk), .rst (rst_v[0]), .outA (oa[0]), .outB (ob[0])
    );
    two_bit_counter_n_clock_divider #(.DIV(1)) u_div1 (
        .clk (clk), .rst (rst_v[1]), .outA (oa[1]), .outB (ob[1])
    );
    two_bit_counter_n_clock_divider #(.DIV(5)) u_div5 (
        .clk (clk), .rst (rst_v[2]), .outA (oa[2]), .outB (ob[2])
    );
    two_bit_counter_n_clock_divider #(.DIV(3)) u_div3 (
        .clk (clk), .rst (rst_v[3]), .outA (oa[3]), .outB (ob[3])
    );

    typedef struct {
        int         unit;
        logic [1:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         n_edges[NU];
    int         checks;
    int         errors;
    int         step_no;
    logic [1:0] prev3;
    logic       prev_b5;
    logic       prev_a5;
    int         run_b5;
    int         run_a5;
    bit         seen_b5;
    bit         seen_a5;

    function automatic int div_of(input int u);
        case (u)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    // Push expectations for the coming edge, take the edge, then pop and compare.
    task automatic step();
        exp_t       e;
        logic [1:0] obs;
        logic [1:0] cur3;
        for (int u = 0; u < NU; u++) begin
            e.unit = u;
            if (!rst_v[u]) begin
                n_edges[u] = 0;
                e.exp      = 2'b00;
            end else begin
                n_edges[u] = n_edges[u] + 1;
                e.exp      = 2'((n_edges[u] / div_of(u)) % 4);
            end
            sb.push_back(e);
        end

        @(posedge clk);
        #1;
        step_no++;

        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {oa[e.unit], ob[e.unit]};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL count_div%0d step=%0d observed=%b expected=%b",
                       div_of(e.unit), step_no, obs, e.exp);
            end
        end

        // DIV=3: every change must be a single +1 step (mod 4).
        cur3 = {oa[3], ob[3]};
        if (cur3 !== prev3) begin
            checks++;
            assert (cur3 === 2'(prev3 + 2'd1)) else begin
                errors++;
                $error("FAIL skip_div3 step=%0d observed=%b expected=%b",
                       step_no, cur3, 2'(prev3 + 2'd1));
            end
        end
        prev3 = cur3;

        // DIV=5: outB runs last 5 samples, outA runs last 10 (first run follows reset).
        if (ob[2] !== prev_b5) begin
            if (seen_b5) begin
                checks++;
                assert (run_b5 === 5) else begin
                    errors++;
                    $error("FAIL outb_run_div5 step=%0d observed=%0d expected=5", step_no, run_b5);
                end
            end
            seen_b5 = 1'b1;
            run_b5  = 1;
        end else begin
            run_b5++;
        end
        prev_b5 = ob[2];

        if (oa[2] !== prev_a5) begin
            if (seen_a5) begin
                checks++;
                assert (run_a5 === 10) else begin
                    errors++;
                    $error("FAIL outa_run_div5 step=%0d observed=%0d expected=10", step_no, run_a5);
                end
            end
            seen_a5 = 1'b1;
            run_a5  = 1;
        end else begin
            run_a5++;
        end
        prev_a5 = oa[2];

        $display("step %0d rst=%b outA=%b outB=%b", step_no, rst_v, oa, ob);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        prev3   = 2'b00;
        prev_b5 = 1'b0;
        prev_a5 = 1'b0;
        run_b5  = 0;
        run_a5  = 0;
        seen_b5 = 1'b0;
        seen_a5 = 1'b0;
        for (int u = 0; u < NU; u++) n_edges[u] = 0;

        // Reset held: all outputs must read 00 on each edge.
        rst_v = '0;
        repeat (3) step();

        // Release: DIV=2 reaches 10 with divider mid-phase after 5 edges.
        rst_v = '1;
        repeat (5) step();

        // One-edge reset on the DIV=2 unit only, overriding the pending tick.
        rst_v[0] = 1'b0;
        step();
        rst_v[0] = 1'b1;

        // Long run covering several wraps of every instance.
        repeat (100) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
